checker_seq_ctrl: RTL and testbench

Sequencer that drives one checker-class FSM benchmark through a pseudo-random stimulus run. On a `start` request it resets the DUT, applies `run_len` LFSR-generated input vectors and compacts the DUT's Mealy outputs into a 16-bit MISR signature. At the end it reports pass/fail against a golden signature. It sits between the bench/host and a single FSM instance (10 inputs, 11 outputs) and also monitors for stuck all-zero output runs.

---
 rtl/checker_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_checker_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/checker_seq_ctrl.sv
// Stimulus sequencer for one FSM benchmark: resets the DUT, drives LFSR
// vectors, compacts outputs into a MISR and compares with a golden value.
module checker_seq_ctrl #(
    parameter int N_IN    = 10,
    parameter int N_OUT   = 11,
    parameter int RST_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      seed,
    input  logic [15:0]      run_len,
    input  logic [15:0]      golden,
    output logic             dut_rst,
    output logic [N_IN-1:0]  dut_x,
    input  logic [N_OUT-1:0] dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      signature,
    output logic [15:0]      vec_count,
    output logic [7:0]       zero_run_max
);

    typedef enum logic [1:0] {IDLE, RST_DUT, RUN, DONE} state_t;

    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [15:0] RC_LAST   = 16'(RST_CYC - 1);

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] len;
    logic [15:0] gold;
    logic [15:0] rcnt;
    logic [7:0]  zcur;

    logic [15:0] yext;
    logic [15:0] sig_nxt;
    logic [15:0] lfsr_nxt;
    logic [7:0]  zcur_nxt;
    logic [7:0]  zmax_nxt;
    logic        last;

    // MISR and LFSR share x^16+x^14+x^13+x^11+1
    always_comb begin
        yext = '0;
        yext[N_OUT-1:0] = dut_y;
        sig_nxt = {signature[14:0],
                   signature[15] ^ signature[13] ^ signature[12] ^ signature[10]} ^ yext;
        lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (yext == 16'd0)
            zcur_nxt = (zcur == 8'hFF) ? 8'hFF : zcur + 8'd1;
        else
            zcur_nxt = 8'd0;
        zmax_nxt = (zcur_nxt > zero_run_max) ? zcur_nxt : zero_run_max;
        last = (vec_count + 16'd1) == len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dut_rst      <= 1'b1;
            dut_x        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            signature    <= 16'd0;
            vec_count    <= 16'd0;
            zero_run_max <= 8'd0;
            zcur         <= 8'd0;
            lfsr         <= LFSR_INIT;
            len          <= 16'd0;
            gold         <= 16'd0;
            rcnt         <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    dut_rst <= 1'b0;
                    done    <= 1'b0;
                    if (start) begin
                        len          <= run_len;
                        gold         <= golden;
                        lfsr         <= (seed == 16'd0) ? LFSR_INIT : seed;
                        signature    <= 16'd0;
                        vec_count    <= 16'd0;
                        zero_run_max <= 8'd0;
                        zcur         <= 8'd0;
                        rcnt         <= 16'd0;
                        if (run_len != 16'd0) begin
                            state   <= RST_DUT;
                            dut_rst <= 1'b1;
                            busy    <= 1'b1;
                            pass    <= 1'b0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (golden == 16'd0);
                        end
                    end
                end
                RST_DUT: begin
                    if (rcnt == RC_LAST) begin
                        state   <= RUN;
                        dut_rst <= 1'b0;
                        dut_x   <= lfsr[N_IN-1:0];
                    end else begin
                        rcnt <= rcnt + 16'd1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else begin
                        signature    <= sig_nxt;
                        lfsr         <= lfsr_nxt;
                        vec_count    <= vec_count + 16'd1;
                        zcur         <= zcur_nxt;
                        zero_run_max <= zmax_nxt;
                        // dut_x keeps the final vector once the run ends
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (sig_nxt == gold);
                        end else begin
                            dut_x <= lfsr_nxt[N_IN-1:0];
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_checker_seq_ctrl.sv
// Directed bench for checker_seq_ctrl: expected run results are queued at
// start and compared when done pulses.
module tb_checker_seq_ctrl;

    localparam int RST_CYC = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] seed;
    logic [15:0] run_len;
    logic [15:0] golden;
    logic        dut_rst;
    logic [9:0]  dut_x;
    logic [10:0] dut_y;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [15:0] vec_count;
    logic [7:0]  zero_run_max;

    int          total = 0;
    int          bad = 0;
    int          rk = 0;
    int          ymode = 0;
    int          ab_at = -1;
    logic [10:0] ycon = 11'd0;

    typedef struct {
        string       tag;
        logic [15:0] sig;
        logic [15:0] cnt;
        logic [7:0]  zmax;
        logic        pass;
        int          lat;
        int          rstc;
    } exp_t;

    exp_t        sb[$];
    logic [9:0]  mx[$];
    logic [15:0] ms[$];

    checker_seq_ctrl #(.N_IN(10), .N_OUT(11), .RST_CYC(RST_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .seed(seed), .run_len(run_len), .golden(golden),
        .dut_rst(dut_rst), .dut_x(dut_x), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass),
        .signature(signature), .vec_count(vec_count),
        .zero_run_max(zero_run_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] yfun(int mode, logic [9:0] x, int k, logic [10:0] yc);
        if (mode == 1) return (k == 20) ? 11'd1 : 11'd0;
        if (mode == 2) return {x[0], x ^ {x[4:0], x[9:5]}};
        return yc;
    endfunction

    // RUN-cycle index seen by the stub FSM
    always @(posedge clk) begin
        if (!busy) rk <= 0;
        else if (!dut_rst) rk <= rk + 1;
    end

    always_comb dut_y = yfun(ymode, dut_x, rk, ycon);
    assign abort = (ab_at >= 0) && busy && !dut_rst && (rk == ab_at);

    function automatic void model(input logic [15:0] sd, input int len, input int ab,
                                  input logic [15:0] gold, input int mode,
                                  input logic [10:0] yc, output exp_t e);
        logic [15:0] l, s;
        logic [10:0] y;
        int cur, mxz, n;
        bit abd;
        l = (sd == 16'd0) ? 16'hACE1 : sd;
        s = 16'd0;
        cur = 0;
        mxz = 0;
        abd = (ab >= 0) && (ab < len);
        n = abd ? ab : len;
        mx.delete();
        ms.delete();
        for (int i = 0; i < n; i++) begin
            mx.push_back(l[9:0]);
            ms.push_back(s);
            y = yfun(mode, l[9:0], i, yc);
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {5'd0, y};
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            if (y == 11'd0) cur = (cur == 255) ? 255 : cur + 1;
            else cur = 0;
            if (cur > mxz) mxz = cur;
        end
        e.sig  = s;
        e.cnt  = 16'(n);
        e.zmax = 8'(mxz);
        e.pass = !abd && (s == gold);
        e.lat  = (len == 0) ? 0 : RST_CYC + (abd ? ab + 1 : len);
        e.rstc = (len == 0) ? 0 : RST_CYC;
    endfunction

    function automatic logic [15:0] sig_of(logic [15:0] sd, int len, int mode, logic [10:0] yc);
        exp_t e;
        model(sd, len, -1, 16'd0, mode, yc, e);
        return e.sig;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [15:0] sd, input int len,
                       input logic [15:0] gold, input int mode, input logic [10:0] yc,
                       input int ab, input bit trace, input int st_at);
        exp_t e, g;
        int cyc, rc, i;
        bit seen;
        model(sd, len, ab, gold, mode, yc, e);
        e.tag = tag;
        sb.push_back(e);
        ymode = mode;
        ycon = yc;
        ab_at = ab;
        seed = sd;
        run_len = 16'(len);
        golden = gold;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        rc = 0;
        i = 0;
        seen = 0;
        while (cyc < 2000) begin
            if (dut_rst) rc++;
            if (done) begin
                seen = 1;
                break;
            end
            start = 1'b0;
            if (busy && !dut_rst) begin
                if (trace && i < mx.size()) begin
                    chk({tag, " x"}, 32'(dut_x), 32'(mx[i]));
                    chk({tag, " sig_step"}, 32'(signature), 32'(ms[i]));
                end
                if (i == st_at) begin
                    start = 1'b1;
                    run_len = 16'd3;
                end
                i++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        ab_at = -1;
        g = sb.pop_front();
        chk({g.tag, " done_seen"}, 32'(seen), 32'd1);
        chk({g.tag, " latency"}, 32'(cyc), 32'(g.lat));
        chk({g.tag, " rst_cycles"}, 32'(rc), 32'(g.rstc));
        chk({g.tag, " busy"}, 32'(busy), 32'd0);
        chk({g.tag, " sig"}, 32'(signature), 32'(g.sig));
        chk({g.tag, " count"}, 32'(vec_count), 32'(g.cnt));
        chk({g.tag, " zmax"}, 32'(zero_run_max), 32'(g.zmax));
        chk({g.tag, " pass"}, 32'(pass), 32'(g.pass));
        @(posedge clk);
        #1;
        chk({g.tag, " done_pulse"}, 32'(done), 32'd0);
        chk({g.tag, " pass_hold"}, 32'(pass), 32'(g.pass));
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        start = 1'b0;
        seed = 16'd0;
        run_len = 16'd0;
        golden = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst dut_rst", 32'(dut_rst), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst pass", 32'(pass), 32'd0);
        chk("rst sig", 32'(signature), 32'd0);
        chk("rst count", 32'(vec_count), 32'd0);
        chk("rst zmax", 32'(zero_run_max), 32'd0);
        chk("rst x", 32'(dut_x), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst release", 32'(dut_rst), 32'd0);

        run("zero_len_g0", 16'h1234, 0, 16'h0000, 0, 11'd0, -1, 0, -1);
        run("zero_len_g1", 16'h1234, 0, 16'h0001, 0, 11'd0, -1, 0, -1);
        run("const", 16'h0000, 2, 16'h0003, 0, 11'h001, -1, 1, -1);
        chk("const first x", 32'(mx[0]), 32'h0E1);
        run("stuck", 16'h5A5A, 26, 16'h0020, 1, 11'd0, -1, 0, -1);
        run("saturate", 16'h0BEE, 300, 16'h0000, 0, 11'd0, -1, 0, -1);
        run("hash", 16'hC0DE, 40, sig_of(16'hC0DE, 40, 2, 11'd0), 2, 11'd0, -1, 1, -1);
        run("abort", 16'h7777, 100, 16'h0000, 2, 11'd0, 9, 0, -1);
        run("abort_last", 16'h4321, 5, sig_of(16'h4321, 5, 2, 11'd0), 2, 11'd0, 4, 0, -1);
        run("start_in_run", 16'h2468, 30, sig_of(16'h2468, 30, 2, 11'd0), 2, 11'd0, -1, 1, 5);

        // reset during RUN
        ymode = 0;
        ycon = 11'h3FF;
        seed = 16'h1111;
        run_len = 16'd50;
        golden = 16'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (RST_CYC + 5) @(posedge clk);
        #1;
        chk("midrst pre count", 32'(vec_count), 32'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst count", 32'(vec_count), 32'd0);
        chk("midrst sig", 32'(signature), 32'd0);
        chk("midrst zmax", 32'(zero_run_max), 32'd0);
        chk("midrst x", 32'(dut_x), 32'd0);
        chk("midrst dut_rst", 32'(dut_rst), 32'd1);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            if (done) seen = 1;
            @(posedge clk);
            #1;
        end
        chk("midrst no_done", 32'(seen), 32'd0);
        run("after_rst", 16'h9999, 12, sig_of(16'h9999, 12, 2, 11'd0), 2, 11'd0, -1, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
